// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_pkg
// Description : Shared types and constants for the SAR conversion controller:
//               one-hot state encoding, settle-counter width and index-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

  localparam int STATE_W = 5;
  // Wide enough for the largest settle preload (SETTLE_CYCLES-1 = 14).
  localparam int CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 5'b00001,
    ST_SET    = 5'b00010,
    ST_SETTLE = 5'b00100,
    ST_DECIDE = 5'b01000,
    ST_DONE   = 5'b10000
  } sar_state_t;

  // Width of the bit-under-test index; never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_settle_timer.sv
`default_nettype none
// ============================================================================
// Module      : sar_settle_timer
// Description : Loadable down-counter with a zero flag. Load wins over
//               decrement; the count saturates at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: preload, decrement towards zero, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, advancing only on enabled ticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sar_controller.sv
`default_nettype none
// ============================================================================
// Module      : sar_controller
// Description : N-bit successive-approximation controller. Drives the R2R
//               DAC trial code, waits a programmable settle time per bit,
//               samples the comparator, and publishes the result with a
//               start/busy/done handshake and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_controller
  import sar_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          comp_in,
  output logic [WIDTH-1:0]              dac_code,
  output logic [WIDTH-1:0]              result,
  output logic                          busy,
  output logic                          done,
  output logic [idx_width(WIDTH)-1:0]   bit_index,
  output logic [STATE_W-1:0]            current_state
);

  localparam int IDX_W = idx_width(WIDTH);
  // SET preloads SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES ticks.
  localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] SETTLE_LOAD_V = CNT_W'(SETTLE_LOAD);
  localparam logic [IDX_W-1:0] IDX_MSB       = IDX_W'(WIDTH - 1);

  sar_state_t       state_q, state_d;
  logic [WIDTH-1:0] sar_q, sar_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             in_conv;

  sar_settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD_V),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign in_conv = (state_q == ST_SET) || (state_q == ST_SETTLE) ||
                   (state_q == ST_DECIDE);

  // Next-state and datapath decode; abort overrides every busy-state move.
  always_comb begin
    state_d  = state_q;
    sar_d    = sar_q;
    result_d = result_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sar_d   = '0;
          idx_d   = IDX_MSB;
          state_d = ST_SET;
        end
      end
      ST_SET: begin
        sar_d[idx_q] = 1'b1;
        tmr_load     = 1'b1;
        state_d      = (SETTLE_CYCLES == 0) ? ST_DECIDE : ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (!comp_in) begin
          sar_d[idx_q] = 1'b0;
        end
        if (idx_q == '0) begin
          // Capture includes the decision made on this tick.
          result_d = sar_d;
          state_d  = ST_DONE;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = ST_SET;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && in_conv) begin
      state_d  = ST_IDLE;
      sar_d    = '0;
      result_d = result_q;
      idx_d    = idx_q;
    end
  end

  // State and datapath registers; everything holds when enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sar_q    <= '0;
      result_q <= '0;
      idx_q    <= IDX_MSB;
    end else if (enable) begin
      state_q  <= state_d;
      sar_q    <= sar_d;
      result_q <= result_d;
      idx_q    <= idx_d;
    end
  end

  assign dac_code      = sar_q;
  assign result        = result_q;
  assign busy          = in_conv;
  assign done          = (state_q == ST_DONE);
  assign bit_index     = idx_q;
  assign current_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_controller
// Description : Self-checking bench for sar_controller. An ideal comparator
//               closes the loop; expected trial codes, latencies and results
//               come from an arithmetic binary-search model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sar_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset  = 1'b1;
  // 8-bit, 2-tick settle instance
  logic       en8    = 1'b0;
  logic       start8 = 1'b0;
  logic       abort8 = 1'b0;
  logic [7:0] vin8   = 8'h00;
  logic       comp8;
  logic [7:0] dac8, res8;
  logic       busy8, done8;
  logic [2:0] bi8;
  logic [4:0] st8;
  // 4-bit, no-settle instance
  logic       en4    = 1'b0;
  logic       start4 = 1'b0;
  logic       abort4 = 1'b0;
  logic [3:0] vin4   = 4'h0;
  logic       comp4;
  logic [3:0] dac4, res4;
  logic       busy4, done4;
  logic [1:0] bi4;
  logic [4:0] st4;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_res8 = 8'h00;

  assign comp8 = (vin8 >= dac8);
  assign comp4 = (vin4 >= dac4);

  sar_controller #(.WIDTH(8), .SETTLE_CYCLES(2)) dut8 (
    .clk(clk), .reset(reset), .enable(en8), .start(start8), .abort(abort8),
    .comp_in(comp8), .dac_code(dac8), .result(res8), .busy(busy8),
    .done(done8), .bit_index(bi8), .current_state(st8)
  );

  sar_controller #(.WIDTH(4), .SETTLE_CYCLES(0)) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .start(start4), .abort(abort4),
    .comp_in(comp4), .dac_code(dac4), .result(res4), .busy(busy4),
    .done(done4), .bit_index(bi4), .current_state(st4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // i-th trial code (MSB first) of an ideal w-bit binary search for v.
  function automatic logic [31:0] trial(input int v, input int w, input int i);
    int p = 0;
    for (int b = w - 1; b > w - 1 - i; b--) begin
      if (v >= (p + (1 << b))) p += (1 << b);
    end
    return 32'(p + (1 << (w - 1 - i)));
  endfunction

  task automatic reset_vals8(input string tag);
    chk({tag, "_dac"},    dac8,  0);
    chk({tag, "_result"}, res8,  0);
    chk({tag, "_busy"},   busy8, 0);
    chk({tag, "_done"},   done8, 0);
    chk({tag, "_bitidx"}, bi8,   7);
    chk({tag, "_state"},  st8,   5'b00001);
  endtask

  // One full 8-bit conversion; cycle k is k cycles after the start cycle t0.
  task automatic conv8(input logic [7:0] v, input bit toggle, input bit pulses,
                       input string tag);
    int mult       = toggle ? 2 : 1;
    int budget     = mult * 33 + 6;
    int done_first = 0;
    int done_cnt   = 0;
    int busy_cnt   = 0;
    int frozen_err = 0;
    bit done_66    = 1'b0;
    logic [25:0] snap;
    logic [25:0] prev = '0;
    @(negedge clk);
    vin8 = v; start8 = 1'b1; en8 = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      snap = {dac8, res8, busy8, done8, bi8, st8};
      if (done8 === 1'b1) begin
        done_cnt++;
        if (done_first == 0) done_first = k;
        if (k == 66) done_66 = 1'b1;
      end
      if (busy8 === 1'b1) busy_cnt++;
      if (toggle && (k % 2 == 0) && (snap !== prev)) frozen_err++;
      for (int i = 0; i < 8; i++) begin
        if (k == mult * 4 * (i + 1))
          chk($sformatf("%s_dac_bit%0d", tag, 7 - i), dac8, trial(v, 8, i));
      end
      prev   = snap;
      start8 = pulses && (k == 3 || k == 10 || k == 20 || k == 33);
      en8    = toggle ? (k % 2 == 0) : 1'b1;
    end
    start8 = 1'b0; en8 = 1'b1;
    if (toggle) begin
      chk({tag, "_done_at_66"}, done_66, 1);
      chk({tag, "_no_early_done"}, (done_first >= 65), 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 64);
      chk({tag, "_frozen_err"}, frozen_err, 0);
    end else begin
      chk({tag, "_done_cycle"}, done_first, 33);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_busy_cycles"}, busy_cnt, 32);
    end
    exp_res8 = v;
    chk({tag, "_result"}, res8, exp_res8);
    chk({tag, "_final_dac"}, dac8, v);
    chk({tag, "_idle"}, st8, 5'b00001);
  endtask

  initial begin
    int dcnt;
    int settle_seen;
    int done_first;

    // Reset with enable low: reset still wins.
    repeat (3) @(negedge clk);
    reset_vals8("rst8");
    chk("rst4_bitidx", bi4, 3);
    chk("rst4_state", st4, 5'b00001);
    reset = 1'b0;
    en8 = 1'b1; en4 = 1'b1;
    @(negedge clk);

    conv8(8'hA5, 1'b0, 1'b0, "a5");
    conv8(8'h00, 1'b0, 1'b0, "zero");
    conv8(8'hFF, 1'b0, 1'b0, "ff");
    conv8(8'h3C, 1'b1, 1'b0, "tog3c");

    // Abort on the fifth DECIDE (cycle 20).
    dcnt = 0;
    @(negedge clk);
    vin8 = 8'h33; start8 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) chk("abort_in_decide", st8, 5'b01000);
      if (k == 21) begin
        chk("abort_state", st8, 5'b00001);
        chk("abort_dac", dac8, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_result", res8, exp_res8);
      end
      if (done8 === 1'b1) dcnt++;
      start8 = 1'b0;
      abort8 = (k == 20);
    end
    abort8 = 1'b0;
    chk("abort_no_done", dcnt, 0);
    chk("abort_result_held", res8, exp_res8);
    conv8(8'h5A, 1'b0, 1'b0, "post_abort");

    // Reset during SETTLE of bit 3 (cycle 18).
    @(negedge clk);
    vin8 = 8'h77; start8 = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 18) begin
        chk("rst_mid_state", st8, 5'b00100);
        chk("rst_mid_bitidx", bi8, 3);
      end
      if (k == 19) reset_vals8("rst_mid");
      start8 = 1'b0;
      reset  = (k == 18);
    end
    reset = 1'b0;
    exp_res8 = 8'h00;

    // Start pulses while busy and in DONE must not launch a second run.
    conv8(8'hC3, 1'b0, 1'b1, "start_busy");

    // 4-bit, no settle.
    dcnt = 0; settle_seen = 0; done_first = 0;
    @(negedge clk);
    vin4 = 4'h9; start4 = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        dcnt++;
        if (done_first == 0) done_first = k;
      end
      if (st4 === 5'b00100) settle_seen++;
      for (int i = 0; i < 4; i++) begin
        if (k == 2 * (i + 1))
          chk($sformatf("w4_dac_bit%0d", 3 - i), dac4, trial(9, 4, i));
      end
      start4 = 1'b0;
    end
    chk("w4_done_cycle", done_first, 9);
    chk("w4_done_count", dcnt, 1);
    chk("w4_no_settle", settle_seen, 0);
    chk("w4_result", res4, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
